// File: rtl/counter_pkg.sv
// ============================================================================
// Module : counter_pkg
// Desc   : Shared mode constants and elaboration helpers for the up/down counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Prescaler counter width; a 1-bit counter is kept even for PRESCALE <= 2.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int width, input int start_point,
                                   input int end_point, input int prescale);
    bit ok;
    ok = (width >= 1) && (width <= 32) && (start_point >= 0) &&
         (start_point <= end_point) && (prescale >= 1);
    if (ok && width < 32)
      ok = (longint'(end_point) < (longint'(1) << width));
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cnt_prescaler.sv
// ============================================================================
// Module : cnt_prescaler
// Desc   : Divides enabled clock cycles by PRESCALE and flags the last one.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic clrn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int                 c_pw   = clog2_min1(PRESCALE);
  localparam logic [c_pw-1:0]    c_last = c_pw'(PRESCALE - 1);

  logic [c_pw-1:0] r_cnt;

  assign tick = (r_cnt == c_last);

  always_ff @(posedge clk) begin
    if (!clrn || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_updown_mod.sv
// ============================================================================
// Module : counter_updown_mod
// Desc   : Bounded up/down counter with load, wrap/saturate and tc pulse.
//          Optional step prescaler enabled by defining CNT_PRESCALER_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int START_POINT = 0,
  parameter int END_POINT   = 9,
  parameter int SATURATE    = 0,
  parameter int PRESCALE    = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] c_start = WIDTH'(START_POINT);
  localparam logic [WIDTH-1:0] c_end   = WIDTH'(END_POINT);
  localparam bit               c_sat   = (SATURATE == MODE_SAT);

  generate
    if (!params_ok(WIDTH, START_POINT, END_POINT, PRESCALE)) begin : g_param_check
      $error("counter_updown_mod: illegal WIDTH/START_POINT/END_POINT/PRESCALE");
    end
  endgenerate

  logic             r_tc;
  logic [WIDTH-1:0] r_q;
  logic             w_tick;
  logic             w_step;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_q;

`ifdef CNT_PRESCALER_EN
  cnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .clrn (clrn),
    .en   (en),
    .clr  (load),
    .tick (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  assign w_step   = en & w_tick;
  assign at_limit = up ? (r_q == c_end) : (r_q == c_start);
  assign w_load_q = ((load_val >= c_start) && (load_val <= c_end)) ? load_val : c_start;

  // At a bound the counter either holds (saturate) or jumps to the opposite bound.
  always_comb begin
    w_next = r_q;
    if (up) begin
      if (r_q != c_end)  w_next = r_q + 1'b1;
      else if (!c_sat)   w_next = c_start;
    end else begin
      if (r_q != c_start) w_next = r_q - 1'b1;
      else if (!c_sat)    w_next = c_end;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_q  <= c_start;
      r_tc <= 1'b0;
    end else if (load) begin
      r_q  <= w_load_q;
      r_tc <= 1'b0;
    end else if (w_step) begin
      r_q  <= w_next;
      r_tc <= at_limit;
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign q  = r_q;
  assign tc = r_tc;

endmodule

`default_nettype wire

// File: tb/tb_counter_updown_mod.sv
// ============================================================================
// Module : tb_counter_updown_mod
// Desc   : Directed checks of a wrap and a saturate counter (2..9) sharing stimulus.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       clrn, en, up, load;
  logic [3:0] load_val;
  logic [3:0] q_w, q_s;
  logic       tc_w, tc_s, al_w, al_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  counter_updown_mod #(
    .WIDTH(4), .START_POINT(2), .END_POINT(9), .SATURATE(0), .PRESCALE(4)
  ) dut_w (
    .clk(clk), .clrn(clrn), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q_w), .tc(tc_w), .at_limit(al_w)
  );

  counter_updown_mod #(
    .WIDTH(4), .START_POINT(2), .END_POINT(9), .SATURATE(1), .PRESCALE(4)
  ) dut_s (
    .clk(clk), .clrn(clrn), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q_s), .tc(tc_s), .at_limit(al_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifndef CNT_PRESCALER_EN
  // Expected values after each of ten up-steps from q=2.
  logic [3:0] exp_qw  [10] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd2, 4'd3, 4'd4};
  logic       exp_tcw [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  logic       exp_alw [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  logic [3:0] exp_qs  [10] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
  logic       exp_tcs [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
  logic       exp_als [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
`endif

  initial begin
    clrn = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
    tick();
    check("reset_q_w", q_w, 2);
    check("reset_tc_w", tc_w, 0);
    check("reset_q_s", q_s, 2);
    check("reset_al_w", al_w, 0);

`ifdef CNT_PRESCALER_EN
    clrn = 1'b1; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("pre_wait_q", q_w, 2);
    end
    tick();
    check("pre_step1_q", q_w, 3);
    tick(); tick();
    en = 1'b0;
    tick(); tick();
    check("pre_pause_q", q_w, 3);
    en = 1'b1;
    tick();
    check("pre_stretch_q", q_w, 3);
    tick();
    check("pre_step2_q", q_w, 4);
    tick(); tick();
    load = 1'b1; load_val = 4'd5;
    tick();
    check("pre_load_q", q_w, 5);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pre_restart_q", q_w, 5);
    end
    tick();
    check("pre_step3_q", q_w, 6);
    check("pre_step3_s", q_s, 6);
`else
    clrn = 1'b1; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("up_q_w", q_w, exp_qw[i]);
      check("up_tc_w", tc_w, exp_tcw[i]);
      check("up_al_w", al_w, exp_alw[i]);
      check("up_q_s", q_s, exp_qs[i]);
      check("up_tc_s", tc_s, exp_tcs[i]);
      check("up_al_s", al_s, exp_als[i]);
    end

    up = 1'b0;
    tick();
    check("sat_down_q", q_s, 8);
    check("sat_down_tc", tc_s, 0);
    check("wrap_down_q", q_w, 3);

    load = 1'b1; load_val = 4'd3;
    tick();
    check("load3_q_w", q_w, 3);
    check("load3_q_s", q_s, 3);
    load = 1'b0;
    tick();
    check("dn_q_w_2", q_w, 2);
    check("dn_tc_w_2", tc_w, 0);
    check("dn_al_w", al_w, 1);
    tick();
    check("dn_q_w_9", q_w, 9);
    check("dn_tc_w_9", tc_w, 1);
    check("dn_q_s_hold", q_s, 2);
    check("dn_tc_s_hold", tc_s, 1);
    tick();
    check("dn_q_w_8", q_w, 8);
    check("dn_tc_w_8", tc_w, 0);
    check("dn_tc_s_again", tc_s, 1);

    up = 1'b1; load = 1'b1; load_val = 4'd6;
    tick();
    check("load_prio_q", q_w, 6);
    check("load_prio_tc", tc_w, 0);
    load_val = 4'd12;
    tick();
    check("load_clamp_q", q_w, 2);
    load_val = 4'd9;
    tick();
    check("load9_q", q_w, 9);
    load = 1'b0;
    tick();
    check("load9_step_q_w", q_w, 2);
    check("load9_step_tc_w", tc_w, 1);
    check("load9_step_q_s", q_s, 9);
    check("load9_step_tc_s", tc_s, 1);

    load = 1'b1; load_val = 4'd7; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    clrn = 1'b0;
    #3;
    check("rst_async_q", q_w, 7);
    tick();
    check("rst_q", q_w, 2);
    check("rst_tc", tc_w, 0);
    tick();
    check("rst_hold_q", q_w, 2);
    clrn = 1'b1; en = 1'b0;
    tick();
    check("en0_q", q_w, 2);
    check("en0_tc", tc_w, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised successor to the board-level free-running counter.
- Counts up or down between programmable start and end points, with enable, synchronous load, and wrap or saturate modes.
- Produces a one-cycle terminal-count pulse.
- Sits between board clock/key inputs and display/LED drivers on the DE10-Lite designs; also usable as a generic timebase/event counter.

Parameters:
- WIDTH, 4, counter width in bits (1..32).
- START_POINT, 0, lower bound and reset value; must satisfy START_POINT <= END_POINT < 2**WIDTH.
- END_POINT, 9, upper bound.
- SATURATE, 0, boundary mode: 0 = wrap, 1 = saturate (hold at bound).
- PRESCALE, 4, number of enabled clk cycles per count step; used only when CNT_PRESCALER_EN is defined; must be >= 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- clrn  in  1  synchronous active-low reset.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  counter value (registered).
- tc  out  1  terminal-count pulse (registered).
- at_limit  out  1  combinational flag: high when q == END_POINT and up == 1, or q == START_POINT and up == 0.

Behaviour:
- Reset and clock:
  - Single clock domain.
  - Reset is synchronous and active-low: clrn sampled low at a rising clk edge.
  - Reset values: q = START_POINT, tc = 0, prescaler count = 0.
- Priority per edge: clrn > load > step > hold.
- Load:
  - If START_POINT <= load_val <= END_POINT, then q <= load_val; otherwise q <= START_POINT.
  - tc <= 0.
  - The prescaler count is cleared.
  - load overrides en/step in the same cycle.
- Step event:
  - step = en & tick.
  - tick = 1 when the prescaler is compiled out.
- Up step:
  - If q != END_POINT, then q <= q + 1.
  - If q == END_POINT: q <= START_POINT when SATURATE = 0; q holds when SATURATE = 1.
- Down step:
  - If q != START_POINT, then q <= q - 1.
  - If q == START_POINT: q <= END_POINT when SATURATE = 0; q holds when SATURATE = 1.
- tc:
  - tc <= 1 in the cycle after any step taken while at_limit = 1, in both modes. In saturate mode it therefore pulses on every step attempted at the bound.
  - Otherwise tc <= 0; it is never high for two cycles unless steps occur on consecutive cycles at the bound.
- Other cases:
  - en = 0: q and tc hold / tc clears; there is no implicit step.
  - up may change on any cycle and takes effect on the next step.
  - Arithmetic is WIDTH bits and never exceeds the bounds. With END_POINT = 2**WIDTH-1 the wrap goes to START_POINT, not to 0 unless START_POINT = 0.
  - START_POINT == END_POINT: q is constant, and every step produces tc.
  - Reset mid-operation, including during a load or a tc pulse, forces the reset values on that edge.
- Latency: q and tc update on the same edge that samples the step; at_limit follows q combinationally.

Optional Feature:
- Macro: CNT_PRESCALER_EN.
- Defined:
  - Internal counter of width $clog2(PRESCALE) (minimum 1) advances only while en = 1.
  - tick = 1 when prescaler == PRESCALE-1, at which point the prescaler returns to 0.
  - When en = 0 the prescaler holds.
  - Reset and load clear it.
- Undefined: tick = 1 constantly and the prescaler is not synthesised; behaviour is identical to PRESCALE = 1.

Decomposition:
- Package counter_pkg:
  - MODE_WRAP = 0 and MODE_SAT = 1 constants.
  - Function clog2_min1 for prescaler width.
  - Parameter-check helper for the START/END/WIDTH legality assertion at elaboration.
- One natural sub-module, cnt_prescaler (parameter PRESCALE; ports clk, clrn, en, clr, tick), instantiated only under CNT_PRESCALER_EN.

Test Plan:
- Wrap up, no prescaler (WIDTH=4, START=2, END=9, SATURATE=0): reset, en=1, up=1 for 10 cycles.
  - Expect q = 2,3,...,9,2,3.
  - Expect tc high exactly one cycle, the cycle q becomes 2 after 9.
  - Expect at_limit high while q = 9.
- Down wrap, same config: load 3, then en=1, up=0.
  - Expect q = 3,2,9,8.
  - Expect tc high on the cycle q = 9.
- Saturate (SATURATE=1): count up to 9 and hold en for 3 more cycles.
  - Expect q stays 9.
  - Expect tc high on each of those 3 cycles.
  - Then up=0: q = 8, tc = 0.
- Load priority and clamp:
  - load=1, load_val=6, en=1 in the same cycle: expect q = 6, no increment.
  - load_val=12 (out of range): expect q = 2.
  - load_val=9 then a step up: expect q = 2 with tc.
- Synchronous reset mid-count:
  - At q = 7, drive clrn=0 between edges: q unchanged until the next rising edge, then q = 2, tc = 0.
  - Hold clrn low with en=1: q stays 2.
- CNT_PRESCALER_EN defined, PRESCALE=4, en=1:
  - Expect q increments every 4th cycle.
  - Drop en for 2 cycles mid-period: the period stretches by 2.
  - A load mid-period restarts the 4-cycle period.
